// File: rtl/add_round_key_stage_pkg.sv
// ============================================================================
// Module      : add_round_key_stage_pkg
// Description : Shared types and constants for the CLM-encoded AddRoundKey stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_round_key_stage_pkg;

    // Masking order; each byte is carried as an (8+d)-bit linear encoding.
    localparam int unsigned d          = 2;
    localparam int unsigned AES_MAX_NR = 14;
    localparam int unsigned NB         = 16;

    typedef logic [8+d-1:0]     red_poly_t;
    typedef red_poly_t [NB-1:0] state_vec_t;

    typedef enum logic [1:0] {
        RND_INIT  = 2'd0,
        RND_MID   = 2'd1,
        RND_FINAL = 2'd2
    } rnd_phase_e;

    function automatic rnd_phase_e rnd_phase(input logic [3:0] r, input int unsigned nr);
        if (r == 4'd0)
            return RND_INIT;
        else if (r == 4'(nr))
            return RND_FINAL;
        else
            return RND_MID;
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_round_key_stage_ctr.sv
// ============================================================================
// Module      : ark_round_ctr
// Description : Round counter for the AddRoundKey stage; wraps after round NR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ark_round_ctr
    import add_round_key_stage_pkg::*;
#(
    parameter int unsigned NR = 10
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_adv,
    output logic [3:0] o_rnd,
    output rnd_phase_e o_phase
);

    logic [3:0] r_rnd;
    logic [3:0] w_rnd_nxt;
    rnd_phase_e w_phase;

    always_ff @(posedge clk) begin
        if (rst)
            r_rnd <= 4'd0;
        else
            r_rnd <= w_rnd_nxt;
    end

    always_comb begin
        w_rnd_nxt = r_rnd;
        w_phase   = rnd_phase(r_rnd, NR);
        if (i_adv) begin
            case (w_phase)
                RND_FINAL: w_rnd_nxt = 4'd0;
                default:   w_rnd_nxt = r_rnd + 4'd1;
            endcase
        end
    end

    assign o_rnd   = r_rnd;
    assign o_phase = w_phase;

endmodule

`default_nettype wire

// File: rtl/add_round_key_stage.sv
// ============================================================================
// Module      : add_round_key_stage
// Description : Registered AddRoundKey stage with one-entry valid/ready buffer.
//               Optional macro ARK_KEY_REFRESH_EN adds an encoded-zero refresh.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_round_key_stage
    import add_round_key_stage_pkg::*;
#(
    parameter int unsigned d  = add_round_key_stage_pkg::d,
    parameter int unsigned NR = 10
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  state_vec_t pt_in,
    input  state_vec_t mc_in,
    input  state_vec_t sr_in,
    input  state_vec_t key_in,
`ifdef ARK_KEY_REFRESH_EN
    input  state_vec_t refresh_in,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output state_vec_t out,
    output logic [3:0] out_rnd,
    output logic       out_last,
    output logic [3:0] rnd
);

    if (NR > AES_MAX_NR || NR == 0) begin : g_chk_nr
        $error("add_round_key_stage: NR out of range");
    end
    if (d != add_round_key_stage_pkg::d) begin : g_chk_d
        $error("add_round_key_stage: d must match the package masking order");
    end

    logic       r_out_valid;
    state_vec_t r_out;
    logic [3:0] r_out_rnd;
    logic       r_out_last;

    logic       w_accept;
    logic [3:0] w_rnd;
    rnd_phase_e w_phase;
    state_vec_t w_sel;
    state_vec_t w_res;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    ark_round_ctr #(
        .NR (NR)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_accept),
        .o_rnd   (w_rnd),
        .o_phase (w_phase)
    );

    always_comb begin
        w_sel = mc_in;
        case (w_phase)
            RND_INIT:  w_sel = pt_in;
            RND_FINAL: w_sel = sr_in;
            default:   w_sel = mc_in;
        endcase
    end

    // The encoding is linear, so a plain XOR of encodings is an exact byte XOR.
`ifdef ARK_KEY_REFRESH_EN
    assign w_res = w_sel ^ key_in ^ refresh_in;
`else
    assign w_res = w_sel ^ key_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_rnd   <= 4'd0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_out_rnd   <= w_rnd;
            r_out_last  <= (w_phase == RND_FINAL);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_rnd   = r_out_rnd;
    assign out_last  = r_out_last;
    assign rnd       = w_rnd;

endmodule

`default_nettype wire

// File: tb/tb_add_round_key_stage.sv
// ============================================================================
// Module      : tb_add_round_key_stage
// Description : Self-checking bench for add_round_key_stage (NR=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_round_key_stage;
    import add_round_key_stage_pkg::*;

    localparam int unsigned C_NR = 10;
    localparam int unsigned C_W  = $bits(state_vec_t);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    state_vec_t pt_in = '0, mc_in = '0, sr_in = '0, key_in = '0, refresh_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    state_vec_t out;
    logic [3:0] out_rnd;
    logic       out_last;
    logic [3:0] rnd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_round_key_stage #(.NR(C_NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pt_in      (pt_in),
        .mc_in      (mc_in),
        .sr_in      (sr_in),
        .key_in     (key_in),
`ifdef ARK_KEY_REFRESH_EN
        .refresh_in (refresh_in),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_rnd    (out_rnd),
        .out_last   (out_last),
        .rnd        (rnd)
    );

    // Reference model: block position as an integer in 0..NR, one-entry buffer.
    logic       m_valid = 1'b0;
    state_vec_t m_out   = '0;
    int         m_out_rnd = 0;
    logic       m_last  = 1'b0;
    int         m_pos   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic state_vec_t fill8(input logic [7:0] b);
        state_vec_t r;
        for (int i = 0; i < int'(C_W); i++) r[i/(8+d)][i%(8+d)] = b[i%8];
        return r;
    endfunction

    function automatic state_vec_t rand_state();
        state_vec_t r;
        for (int i = 0; i < int'(C_W); i++) r[i/(8+d)][i%(8+d)] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic model_edge();
        state_vec_t sel;
        if (rst) begin
            m_valid = 0; m_out = '0; m_out_rnd = 0; m_last = 0; m_pos = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            if (m_pos == 0)             sel = pt_in;
            else if (m_pos == int'(C_NR)) sel = sr_in;
            else                        sel = mc_in;
`ifdef ARK_KEY_REFRESH_EN
            m_out = sel ^ key_in ^ refresh_in;
`else
            m_out = sel ^ key_in;
`endif
            m_out_rnd = m_pos;
            m_last    = (m_pos == int'(C_NR));
            m_valid   = 1;
            m_pos     = (m_pos + 1) % (int'(C_NR) + 1);
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model();
        chk("out_valid", 256'(out_valid), 256'(m_valid));
        chk("in_ready",  256'(in_ready),  256'(!m_valid || out_ready));
        chk("rnd",       256'(rnd),       256'(m_pos));
        chk("out",       256'(out),       256'(m_out));
        chk("out_rnd",   256'(out_rnd),   256'(m_out_rnd));
        chk("out_last",  256'(out_last),  256'(m_last));
    endtask

    // One clock: compare against the model mid-cycle, then advance both.
    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        state_vec_t pt, mc, sr, key;
        state_vec_t exp_out;
        logic [3:0] exp_rnd;
        logic       exp_last;
    } vec_t;

    vec_t       vecs[11];
    state_vec_t held, kk, rr, exp_ref;
    int         emits;

    initial begin
        // Full-block table: P in round 0, M in 1..9, S in round 10, key zero.
        for (int i = 0; i < 11; i++) begin
            vecs[i].pt       = fill8(8'h3C);
            vecs[i].mc       = fill8(8'h96);
            vecs[i].sr       = fill8(8'hE1);
            vecs[i].key      = '0;
            vecs[i].exp_out  = (i == 0) ? fill8(8'h3C) : (i == 10) ? fill8(8'hE1) : fill8(8'h96);
            vecs[i].exp_rnd  = 4'(i);
            vecs[i].exp_last = (i == 10);
        end

        // Reset
        rst = 1; step(); step(); rst = 0;
        chk("rst out_valid", 256'(out_valid), 256'(0));
        chk("rst out",       256'(out),       256'(0));
        chk("rst rnd",       256'(rnd),       256'(0));
        chk("rst out_rnd",   256'(out_rnd),   256'(0));
        chk("rst out_last",  256'(out_last),  256'(0));
        chk("rst in_ready",  256'(in_ready),  256'(1));

        // Round 0: A5 ^ 5A gives all ones
        pt_in = fill8(8'hA5); key_in = fill8(8'h5A); mc_in = '0; sr_in = '0;
        in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        chk("r0 out",      256'(out),      256'({C_W{1'b1}}));
        chk("r0 out_rnd",  256'(out_rnd),  256'(0));
        chk("r0 out_last", 256'(out_last), 256'(0));
        chk("r0 rnd",      256'(rnd),      256'(1));

        // Full block, back to back
        rst = 1; step(); rst = 0;
        emits = 0;
        for (int i = 0; i < 11; i++) begin
            pt_in = vecs[i].pt; mc_in = vecs[i].mc; sr_in = vecs[i].sr; key_in = vecs[i].key;
            in_valid = 1;
            step();
            chk("blk out",      256'(out),      256'(vecs[i].exp_out));
            chk("blk out_rnd",  256'(out_rnd),  256'(vecs[i].exp_rnd));
            chk("blk out_last", 256'(out_last), 256'(vecs[i].exp_last));
            if (out_valid) emits++;
        end
        in_valid = 0;
        step();
        if (out_valid) emits++;
        chk("blk emits",     256'(emits),     256'(11));
        chk("blk rnd wrap",  256'(rnd),       256'(0));
        chk("blk drained",   256'(out_valid), 256'(0));

        // Backpressure at rnd=4
        rst = 1; step(); rst = 0;
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            pt_in = rand_state(); mc_in = rand_state(); sr_in = rand_state(); key_in = rand_state();
            step();
        end
        held = out;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            mc_in = rand_state(); key_in = rand_state();
            step();
            chk("bp out stable", 256'(out),      256'(held));
            chk("bp in_ready",   256'(in_ready), 256'(0));
            chk("bp rnd",        256'(rnd),      256'(4));
            chk("bp out_rnd",    256'(out_rnd),  256'(3));
        end
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            pt_in = rand_state(); mc_in = rand_state(); sr_in = rand_state(); key_in = rand_state();
            step();
        end
        chk("bp last rnd",  256'(out_rnd),  256'(C_NR));
        chk("bp last flag", 256'(out_last), 256'(1));
        chk("bp wrap",      256'(rnd),      256'(0));
        in_valid = 0; step();

        // Mid-block reset after the rnd=5 beat
        rst = 1; step(); rst = 0;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            pt_in = rand_state(); mc_in = rand_state(); sr_in = rand_state(); key_in = rand_state();
            step();
        end
        chk("mbr pre out_rnd", 256'(out_rnd), 256'(5));
        rst = 1; in_valid = 0; step(); rst = 0;
        chk("mbr out_valid", 256'(out_valid), 256'(0));
        chk("mbr rnd",       256'(rnd),       256'(0));
        pt_in = fill8(8'hC3); mc_in = fill8(8'h0F); sr_in = fill8(8'hF0); key_in = fill8(8'h11);
        in_valid = 1; step(); in_valid = 0;
        chk("mbr pt used",  256'(out),     256'(fill8(8'hD2)));
        chk("mbr out_rnd",  256'(out_rnd), 256'(0));

        // Refresh term
        rst = 1; step(); rst = 0;
        kk = rand_state(); rr = rand_state();
        pt_in = '0; key_in = kk; refresh_in = rr;
`ifdef ARK_KEY_REFRESH_EN
        exp_ref = kk ^ rr;
`else
        exp_ref = kk;
`endif
        in_valid = 1; step(); in_valid = 0;
        chk("refresh out", 256'(out), 256'(exp_ref));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            pt_in      = rand_state(); mc_in = rand_state(); sr_in = rand_state();
            key_in     = rand_state(); refresh_in = rand_state();
            step();
        end
        rst = 0; in_valid = 0; out_ready = 1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_round_key_stage.md
# add_round_key_stage

Registered AddRoundKey stage of the CLM-encoded AES datapath, directly downstream of the per-round MixColumns block. Each accepted beat selects the round's input state: encoded plaintext in round 0, the MixColumns output in rounds 1..NR-1, the ShiftRows output in the final round. It XORs the encoded round key into the selected state and holds the result in a one-entry output buffer with valid/ready handshakes. An internal round counter tracks the position in the block cipher and flags the final round.

## Interface
- d, default d (package masking order): masking order; sets polynomial widths via types.
- NR, default 10: number of AES rounds (10/12/14).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- pt_in  in  $bits(state_vec_t)  encoded plaintext; used when rnd==0.
- mc_in  in  $bits(state_vec_t)  MixColumns output; used for rnd in 1..NR-1.
- sr_in  in  $bits(state_vec_t)  ShiftRows output; used for rnd==NR (MixColumns skipped).
- key_in  in  $bits(state_vec_t)  encoded round key for the current rnd.
- refresh_in  in  $bits(state_vec_t)  encoded-zero refresh term; present only with ARK_KEY_REFRESH_EN.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out  out  $bits(state_vec_t)  registered round state.
- out_rnd  out  4  round index of the held output beat.
- out_last  out  1  held beat is the final round (out_rnd==NR).
- rnd  out  4  round index the next accepted beat belongs to.

## Operation
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- in_ready = !out_valid || out_ready (accept and emit in the same cycle allowed).
- On accept: out <= sel ^ key_in (^ refresh_in with macro), per bit over the whole state_vec_t; the encoding is linear, so byte-wise XOR of encodings is exact. out_rnd <= rnd; out_last <= (rnd==NR); out_valid <= 1.
- sel: rnd==0 -> pt_in; 1 <= rnd <= NR-1 -> mc_in; rnd==NR -> sr_in.
- Counter FSM, states are the value of rnd: 0 (INIT), 1..NR-1 (MID), NR (FINAL). Each accept moves rnd to rnd+1; accept in FINAL wraps to 0. No change without an accept.
- On emit without accept: out_valid <= 0; out, out_rnd, out_last hold their values.
- While out_valid && !out_ready: out, out_rnd and out_last are stable, in_ready=0, and rnd is frozen.
- rst overrides everything: rnd=0, out_valid=0, out=0, out_rnd=0, out_last=0. Reset mid-block discards the block; the next accept is round 0.

## Timing
- Latency 1 cycle from accept to out_valid. Throughput 1 beat/cycle when out_ready is held high.
- NR+1 beats per block. out_last is high for exactly the beat carrying round NR.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path.
- key_in and refresh_in are sampled in the accept cycle only.

## Configuration
- ARK_KEY_REFRESH_EN defined: the refresh_in port exists and is XORed into every round result, re-randomizing the encoding. The upstream randomness unit must supply a valid encoding of zero.
- ARK_KEY_REFRESH_EN undefined: the refresh_in port is absent and out = sel ^ key_in. Cycle behaviour is identical in both builds.

## Structure
- Package types: state_vec_t, red_poly_t, d, and a new constant AES_MAX_NR=14 used to check NR (elaboration error if NR > AES_MAX_NR).
- One sub-module, ark_round_ctr: the rnd counter with wrap at NR and the FINAL/INIT decode. The datapath mux, XOR and output buffer stay in the top module.

## Test plan
- Reset: hold rst 2 cycles -> out_valid=0, out=0, rnd=0, out_rnd=0, out_last=0, in_ready=1.
- Round 0: pt_in all bytes 0xA5-pattern bits, key_in 0x5A-pattern, in_valid=1, out_ready=1 -> next cycle out=all-ones pattern, out_rnd=0, out_last=0, rnd=1.
- Full block, NR=10: drive distinct patterns P/M/S on pt_in/mc_in/sr_in with key_in=0 for 11 back-to-back beats -> outputs P, M×9, S. out_last only on beat 10. rnd wraps to 0; 11 outputs in 12 cycles.
- Backpressure: out_ready=0 for 3 cycles at rnd=4 -> out stable, in_ready=0, rnd stays 4. Release -> beats resume with no loss or duplication.
- Mid-block reset: assert rst after the rnd=5 beat -> out_valid=0 the next cycle. The next accept uses pt_in and is tagged out_rnd=0.
- With ARK_KEY_REFRESH_EN: pt_in=0, key_in=K, refresh_in=R -> out=K^R. Without the macro, the same stimulus gives out=K.
